// File: rtl/serial_subtractor_8_bit_if.sv
// serial_subtractor_8_bit_if: request/result bundle for the bit-serial subtractor
//   start  requester -> subtractor  request strobe, sampled only while idle
//   A, B   requester -> subtractor  minuend and subtrahend
//   B_in   requester -> subtractor  borrow in
//   D      subtractor -> requester  registered difference
//   B_out  subtractor -> requester  registered borrow out
//   busy   subtractor -> requester  operation in progress
//   done   subtractor -> requester  one-cycle result-ready pulse
interface serial_subtractor_8_bit_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             B_in;
    logic [WIDTH-1:0] D;
    logic             B_out;
    logic             busy;
    logic             done;
    modport master (output start, A, B, B_in, input D, B_out, busy, done);
    modport slave (input start, A, B, B_in, output D, B_out, busy, done);
endinterface

// File: rtl/serial_subtractor_8_bit.sv
// serial_subtractor_8_bit: bit-serial {B_out, D} = A - B - B_in, LSB first, one bit per clock
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  slave side of serial_subtractor_8_bit_if (start/A/B/B_in in, D/B_out/busy/done out)
module serial_subtractor_8_bit #(
    parameter int WIDTH = 8
) (
    input logic                     clk,
    input logic                     rst,
    serial_subtractor_8_bit_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, state_next;
    logic [WIDTH-1:0] a_sr, b_sr, d_q;
    logic [WIDTH-2:0] res;
    logic [CW-1:0] cnt;
    logic brw, bo_q, diff_bit, brw_next, last_bit;
    always_comb begin
        diff_bit   = a_sr[0] ^ b_sr[0] ^ brw;
        brw_next   = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & brw);
        last_bit   = cnt == CW'(WIDTH - 1);
        state_next = (state == IDLE)  ? (bus.start ? SHIFT : IDLE) :
                     (state == SHIFT) ? (last_bit ? DONE : SHIFT) : IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_next;
    end
    // res collects the low WIDTH-1 difference bits; the final bit is merged
    // straight into D so the outputs only change on the SHIFT->DONE edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr <= '0;
            b_sr <= '0;
            brw  <= 1'b0;
            res  <= '0;
            cnt  <= '0;
            d_q  <= '0;
            bo_q <= 1'b0;
        end else if (state == IDLE && bus.start) begin
            a_sr <= bus.A;
            b_sr <= bus.B;
            brw  <= bus.B_in;
            cnt  <= '0;
        end else if (state == SHIFT) begin
            a_sr <= a_sr >> 1;
            b_sr <= b_sr >> 1;
            brw  <= brw_next;
            res  <= {diff_bit, res[WIDTH-2:1]};
            cnt  <= cnt + CW'(1);
            if (last_bit) begin
                d_q  <= {diff_bit, res};
                bo_q <= brw_next;
            end
        end
    end
    assign bus.D     = d_q;
    assign bus.B_out = bo_q;
    assign bus.busy  = state != IDLE;
    assign bus.done  = state == DONE;
endmodule

// File: tb/tb_serial_subtractor_8_bit.sv
// tb_serial_subtractor_8_bit: scoreboard bench; stimulus pushes expected {B_out,D}, monitor pops on done
module tb_serial_subtractor_8_bit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int errors = 0;
    logic [8:0] q[$];
    logic [8:0] last = '0;
    logic prev_done = 1'b0;
    int busy_n, done_at;

    always #5 clk = ~clk;

    serial_subtractor_8_bit_if bus ();
    serial_subtractor_8_bit dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected result.
    initial forever begin
        @(negedge clk);
        if (prev_done) chk("done_width", int'(bus.done), 0);
        if (bus.done && !prev_done) begin
            if (q.size() == 0) chk("spurious_done", int'(bus.done), 0);
            else chk("result", int'({bus.B_out, bus.D}), int'(q.pop_front()));
        end
        prev_done = bus.done;
    end

    // Runs one operation from idle; optionally pokes start mid-SHIFT or
    // pulses reset at cycle rst_at. Cycle n counts negedges after the accepting edge.
    task automatic op(input logic [7:0] a, input logic [7:0] b, input logic bi,
                      input logic [8:0] exp, input bit push, input int poke, input int rst_at);
        @(negedge clk);
        bus.A = a;
        bus.B = b;
        bus.B_in = bi;
        bus.start = 1'b1;
        if (push) q.push_back(exp);
        busy_n = 0;
        done_at = 0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (n == 2) chk("d_held", int'({bus.B_out, bus.D}), int'(last));
            if (bus.busy) busy_n++;
            if (bus.done) done_at = n;
            if (n == poke) begin
                bus.start = 1'b1;
                bus.A = 8'd1;
                bus.B = 8'd1;
                bus.B_in = 1'b0;
            end else bus.start = 1'b0;
            rst = (n == rst_at);
            if (!bus.busy && !bus.start && !rst) break;
            if (n == 30) chk("op_timeout", int'(bus.busy), 0);
        end
        last = push ? exp : 9'd0;
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic rbi;
        int pushed, cyc;
        bus.start = 1'b0;
        bus.A = '0;
        bus.B = '0;
        bus.B_in = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_state", int'({bus.busy, bus.done, bus.B_out, bus.D}), 0);

        op(8'd100, 8'd37, 1'b0, {1'b0, 8'd63}, 1, -1, -1);
        chk("t1_latency", done_at, 9);
        op(8'd5, 8'd10, 1'b0, {1'b1, 8'd251}, 1, -1, -1);
        chk("t2_busy_cycles", busy_n, 9);
        op(8'd0, 8'd0, 1'b1, {1'b1, 8'd255}, 1, -1, -1);
        op(8'd255, 8'd255, 1'b1, {1'b1, 8'd255}, 1, -1, -1);
        op(8'd0, 8'd255, 1'b1, {1'b1, 8'd0}, 1, -1, -1);
        op(8'd200, 8'd55, 1'b0, {1'b0, 8'd145}, 1, 3, -1);
        chk("t4_busy_cycles", busy_n, 9);
        repeat (3) @(negedge clk);
        chk("t4_no_second_op", int'(bus.busy), 0);

        op(8'd77, 8'd12, 1'b0, 9'd0, 0, -1, 5);
        chk("t5_rst_clear", int'({bus.busy, bus.done, bus.B_out, bus.D}), 0);
        chk("t5_no_done", done_at, 0);
        op(8'd12, 8'd77, 1'b1, {1'b1, 8'd190}, 1, -1, -1);
        chk("t5_after_busy", busy_n, 9);

        // Back-to-back with start held high: new operands go in whenever idle.
        pushed = 0;
        cyc = 0;
        while (pushed < 1000 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (!bus.busy) begin
                ra = 8'($urandom);
                rb = 8'($urandom);
                rbi = 1'($urandom);
                bus.A = ra;
                bus.B = rb;
                bus.B_in = rbi;
                bus.start = 1'b1;
                q.push_back({1'b0, ra} - {1'b0, rb} - {8'd0, rbi});
                pushed++;
            end
        end
        @(negedge clk);
        bus.start = 1'b0;
        chk("b2b_throughput", cyc, 999 * 10 + 1);
        for (int i = 0; i < 30 && bus.busy; i++) @(negedge clk);
        chk("final_idle", int'(bus.busy), 0);
        repeat (2) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
